// File: rtl/mips_register_scoreboard_file_if.sv
// Decode-stage register file bus: operand reads, issue, write-back and stall.
interface mips_register_scoreboard_file_if #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int READ_PORTS = 2
);
    localparam int AW = $clog2(DEPTH);

    logic [READ_PORTS*AW-1:0]    rdAddr;
    logic [READ_PORTS-1:0]       rdValid;
    logic [READ_PORTS*WIDTH-1:0] rdData;
    logic                        portEq;
    logic                        issueValid;
    logic                        issueLoad;
    logic [AW-1:0]               issueAddr;
    logic                        wrEnable;
    logic [AW-1:0]               wrAddr;
    logic [WIDTH-1:0]            wrData;
    logic                        wrLoad;
    logic                        stall;
    logic [AW:0]                 pendingCount;

    modport master (
        output rdAddr, rdValid, issueValid, issueLoad, issueAddr,
        output wrEnable, wrAddr, wrData, wrLoad,
        input  rdData, portEq, stall, pendingCount
    );

    modport slave (
        input  rdAddr, rdValid, issueValid, issueLoad, issueAddr,
        input  wrEnable, wrAddr, wrData, wrLoad,
        output rdData, portEq, stall, pendingCount
    );
endinterface

// File: rtl/mips_register_scoreboard_file.sv
// MIPS register file with per-register load scoreboard and stall output.
// Define MIPS_REGISTER_FILE_BYPASS_EN for same-cycle write-back forwarding.
module mips_register_scoreboard_file #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int READ_PORTS = 2
) (
    input logic clk,
    input logic rst_n,
    mips_register_scoreboard_file_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]      regs_q [DEPTH];
    logic [WIDTH-1:0]      regs_d [DEPTH];
    logic [DEPTH-1:0]      pend_q;
    logic [DEPTH-1:0]      pend_d;
    logic [AW:0]           cnt_q;
    logic [AW:0]           cnt_d;
    logic [AW-1:0]         ra [READ_PORTS];
    logic [WIDTH-1:0]      rd [READ_PORTS];
    logic [READ_PORTS-1:0] fwd_hit;
    logic [READ_PORTS-1:0] hit;
    logic                  stall;
    logic                  issue_set;
    logic                  wb_load;

    assign wb_load = bus.wrEnable & bus.wrLoad;

    always_comb begin
        bus.rdData = '0;
        for (int k = 0; k < READ_PORTS; k++) begin
            ra[k] = bus.rdAddr[k*AW +: AW];
            rd[k] = regs_q[ra[k]];
            fwd_hit[k] = 1'b0;
`ifdef MIPS_REGISTER_FILE_BYPASS_EN
            if (bus.wrEnable && bus.wrAddr == ra[k])
                rd[k] = bus.wrData;
            fwd_hit[k] = wb_load & (bus.wrAddr == ra[k]);
`endif
            // r0 is hardwired; this also masks any forwarded r0 write
            if (ra[k] == '0)
                rd[k] = '0;
            hit[k] = bus.rdValid[k] & pend_q[ra[k]] & ~fwd_hit[k];
            bus.rdData[k*WIDTH +: WIDTH] = rd[k];
        end
    end

    assign stall            = |hit;
    assign bus.stall        = stall;
    assign bus.portEq       = (rd[0] == rd[1]);
    assign bus.pendingCount = cnt_q;

    assign issue_set = bus.issueValid & bus.issueLoad & ~stall
                     & (bus.issueAddr != '0);

    // Set is applied after clear so a newer load to the same reg wins
    always_comb begin
        pend_d = pend_q;
        if (wb_load)
            pend_d[bus.wrAddr] = 1'b0;
        if (issue_set)
            pend_d[bus.issueAddr] = 1'b1;
        pend_d[0] = 1'b0;
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_d = cnt_d + {{AW{1'b0}}, pend_d[i]};
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            regs_d[i] = regs_q[i];
        if (bus.wrEnable && bus.wrAddr != '0)
            regs_d[bus.wrAddr] = bus.wrData;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= '0;
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= regs_d[i];
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: doc/mips_register_scoreboard_file.md
# mips_register_scoreboard_file

Parametrised successor to the two-port register datapath: a DEPTH×WIDTH MIPS register file with READ_PORTS read ports, one write port and a per-register load scoreboard that raises a stall when an instruction reads a register whose load has not yet written back. It sits in the decode stage. Operand addresses come from the decoded instruction. Write-back data and addresses come from the WB stage. The stall output feeds the pipeline hazard unit.

## Interface
Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 32, number of registers (power of two ≥ 2); AW = log2(DEPTH).
- READ_PORTS, 2, number of read ports (≥ 2).

Ports:
- ctrl  input  Data_Control_Control_T bundle  one clock (rising edge) plus reset; reset is asynchronous and active-low.
- rdAddr  input  READ_PORTS*AW  read addresses; port k occupies bits [k*AW +: AW].
- rdValid  input  READ_PORTS  port k is actually consumed by the decoding instruction.
- rdData  output  READ_PORTS*WIDTH  read data; port k occupies bits [k*WIDTH +: WIDTH].
- portEq  output  1  rdData port 0 == rdData port 1 (branch compare).
- issueValid  input  1  decoding instruction issues this cycle (ignored while stall=1).
- issueLoad  input  1  issuing instruction is a load; marks issueAddr pending.
- issueAddr  input  AW  destination register of the issuing instruction.
- wrEnable  input  1  write-back valid.
- wrAddr  input  AW  write-back register.
- wrData  input  WIDTH  write-back data.
- wrLoad  input  1  write-back comes from a load; clears the pending bit of wrAddr.
- stall  output  1  some valid read port hits a pending register.
- pendingCount  output  AW+1  number of set pending bits.

## Operation
- Storage: DEPTH registers of WIDTH bits. Register 0 always reads 0. Writes to register 0 are discarded, and it is never marked pending.
- Write: at the clock edge, if wrEnable=1 and wrAddr≠0, then reg[wrAddr] ← wrData.
- Read: combinational from the current array. Same-cycle write forwarding depends on configuration.
- Scoreboard: one pending bit per register.
  - Set at the edge when issueValid & issueLoad & !stall & issueAddr≠0.
  - Cleared at the edge when wrEnable & wrLoad.
  - If set and clear target the same register in the same cycle, set wins: a newer load is now outstanding.
- Stall: stall = OR over k of (rdValid[k] & pending[rdAddr[k]] & !forwardHit[k]).
  - forwardHit[k] = wrEnable & wrLoad & wrAddr==rdAddr[k] & bypass compiled in; otherwise forwardHit[k] = 0.
- pendingCount: registered. Updated every edge to the popcount of the next pending vector.
- portEq compares the post-forwarding rdData of ports 0 and 1.

## Timing
- Reset (ctrl reset low, asynchronous): all registers 0, all pending bits 0, pendingCount 0. Outputs follow: rdData all 0, portEq 1, stall 0.
- Reads, stall and portEq are zero-latency combinational.
- Writes and scoreboard updates take effect at the rising edge. They are visible to reads in the following cycle, or the same cycle where bypass applies.
- A load issued in cycle N sets pending at edge N. A reader in cycle N+1 or later stalls until the cycle in which the matching wrLoad write-back is presented (with bypass) or the cycle after it (without bypass).
- No overflow is possible: pendingCount ≤ DEPTH-1.
- Reset asserted mid-operation discards all pending loads immediately. A write-back arriving after reset release with no matching pending bit is written normally.

## Configuration
- MIPS_REGISTER_FILE_BYPASS_EN defined:
  - A read port whose address equals wrAddr (≠0) while wrEnable=1 returns wrData in the same cycle.
  - forwardHit suppresses the stall.
- Undefined:
  - Reads return the pre-write array value.
  - forwardHit = 0, so a reader of a register being load-written this cycle stalls one more cycle.

## Test plan
- Reset then read all ports at addresses 1..3 → rdData 0, portEq 1, stall 0, pendingCount 0.
- Write 0xDEADBEEF to r5, then read r5 on ports 0 and 1 next cycle → both 0xDEADBEEF, portEq 1; write r0 = 7 → r0 still reads 0.
- Issue load to r8; next cycle read r8 with rdValid=1 → stall=1, pendingCount 1.
  - Present wrLoad r8 = 0x55: with BYPASS_EN, same cycle stall=0 and rdData 0x55; without BYPASS_EN, stall=1 that cycle and 0 the next.
- Same-cycle issue load r9 and wrLoad r9 → r9 is written, pending stays 1, pendingCount unchanged.
- Issue load r10 while stall=1 → pending[10] stays 0.
- Load r3 and r4 pending (pendingCount 2); assert reset mid-cycle → pendingCount 0, stall 0 immediately, r3 reads 0.
